// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback datapath.
// Captures the MEM-stage result, extracts big-endian load data, drives the
// register-file write port (also the WB bypass source), counts retired
// instructions and flags misaligned halfword/word loads.
module mem_wb_stage #(
  parameter int CNT_W       = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  input  logic             MemValid,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      MemData,
  input  logic [4:0]       RegDst,
  input  logic             RegWrite,
  input  logic             MemToReg,
  input  logic [2:0]       LoadType,
  output logic [31:0]      BusW,
  output logic [4:0]       RW,
  output logic             RegWr,
  output logic             WbValid,
  output logic             AlignErr,
  output logic             AlignErrSticky,
  output logic [CNT_W-1:0] RetireCount
);

  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic             vld_p1;
  logic             we_p1;
  logic             err_p1;
  logic             m2r_p1;
  logic [2:0]       lt_p1;
  logic [4:0]       rd_p1;
  logic [31:0]      res_p1;
  logic [31:0]      mem_p1;
  logic             sticky;
  logic [CNT_W-1:0] retired;

  // Halfword loads need bit 0 clear; word loads (and unknown types) need both
  // low bits clear. Byte loads can never be misaligned.
  function automatic logic misaligned(input logic [1:0] a, input logic [2:0] lt);
    logic bad;
    case (lt)
      LT_LH, LT_LHU: bad = a[0];
      LT_LB, LT_LBU: bad = 1'b0;
      default:       bad = (a != 2'b00);
    endcase
    return bad;
  endfunction

  // Big-endian lane select and sign/zero extension; byte 0 lives in [31:24].
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  a,
                                               input logic [2:0]  lt);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (a)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = a[1] ? word[15:0] : word[31:16];
    case (lt)
      LT_LB:   r = 32'(b);
      LT_LBU:  r = {24'd0, b};
      LT_LH:   r = 32'(h);
      LT_LHU:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // ---- stage p1: MEM/WB capture (fields that reset) ----
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_p1 <= 1'b0;
      we_p1  <= 1'b0;
      err_p1 <= 1'b0;
      rd_p1  <= '0;
      res_p1 <= '0;
      mem_p1 <= '0;
    end else begin
      vld_p1 <= MemValid & ~Flush;
      we_p1  <= RegWrite;
      err_p1 <= ALIGN_CHECK & MemToReg & MemValid & ~Flush
                & misaligned(ALUResult[1:0], LoadType);
      rd_p1  <= RegDst;
      res_p1 <= ALUResult;
      mem_p1 <= MemData;
    end
  end

  // Load-control fields need no reset: BusW is 0 after reset whatever they hold.
  always_ff @(posedge Clk) begin
    m2r_p1 <= MemToReg;
    lt_p1  <= LoadType;
  end

  // Retired-instruction counter and sticky alignment flag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      retired <= '0;
      sticky  <= 1'b0;
    end else begin
      if (vld_p1) retired <= retired + CNT_W'(1);
      if (err_p1) sticky  <= 1'b1;
    end
  end

  // ---- stage p1 outputs: writeback port, purely from registered state ----
  assign BusW           = m2r_p1 ? load_extract(mem_p1, res_p1[1:0], lt_p1) : res_p1;
  assign RW             = rd_p1;
  assign RegWr          = vld_p1 & we_p1 & ~err_p1 & (rd_p1 != 5'd0);
  assign WbValid        = vld_p1;
  assign AlignErr       = err_p1;
  assign AlignErrSticky = sticky;
  assign RetireCount    = retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model. Two instances share
// the inputs: one with a 4-bit counter and alignment checking, one with the
// default 32-bit counter and alignment checking disabled.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, flush, mem_valid, reg_write, mem_to_reg;
  logic [31:0] alu_result, mem_data;
  logic [4:0]  reg_dst;
  logic [2:0]  load_type;

  logic [31:0] busw_a, busw_b;
  logic [4:0]  rw_a, rw_b;
  logic        regwr_a, regwr_b, wbv_a, wbv_b, aerr_a, aerr_b, stk_a, stk_b;
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(4), .ALIGN_CHECK(1'b1)) dut_a (
    .Clk(clk), .Rst(rst), .Flush(flush), .MemValid(mem_valid),
    .ALUResult(alu_result), .MemData(mem_data), .RegDst(reg_dst),
    .RegWrite(reg_write), .MemToReg(mem_to_reg), .LoadType(load_type),
    .BusW(busw_a), .RW(rw_a), .RegWr(regwr_a), .WbValid(wbv_a),
    .AlignErr(aerr_a), .AlignErrSticky(stk_a), .RetireCount(cnt_a)
  );

  mem_wb_stage #(.CNT_W(32), .ALIGN_CHECK(1'b0)) dut_b (
    .Clk(clk), .Rst(rst), .Flush(flush), .MemValid(mem_valid),
    .ALUResult(alu_result), .MemData(mem_data), .RegDst(reg_dst),
    .RegWrite(reg_write), .MemToReg(mem_to_reg), .LoadType(load_type),
    .BusW(busw_b), .RW(rw_b), .RegWr(regwr_b), .WbValid(wbv_b),
    .AlignErr(aerr_b), .AlignErrSticky(stk_b), .RetireCount(cnt_b)
  );

  // Reference model: the instruction currently sitting in WB.
  typedef struct {
    logic        valid;
    logic [31:0] res;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic        we;
    logic        m2r;
    logic [2:0]  lt;
  } wb_t;

  wb_t         cur;
  int unsigned m_cnt_a, m_cnt_b;
  logic        m_stk_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Value a load returns, computed arithmetically from byte offsets.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] addr,
                                           input logic [2:0] lt);
    int unsigned off, v;
    off = addr % 4;
    case (lt)
      3'd3, 3'd4: begin
        v = (w >> (8 * (3 - off))) & 32'hFF;
        if (lt == 3'd3 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd2: begin
        v = (off >= 2) ? (w & 32'hFFFF) : (w >> 16);
        if (lt == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic ref_misaligned(input logic [31:0] addr, input logic [2:0] lt);
    if (lt == 3'd3 || lt == 3'd4) return 1'b0;
    if (lt == 3'd1 || lt == 3'd2) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  // Drive one cycle of inputs, clock it, advance the model and compare.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [31:0] alu, input logic [31:0] md,
                      input logic [4:0] rd, input logic we, input logic m2r,
                      input logic [2:0] lt);
    logic        err_a;
    logic [31:0] exp_busw;
    rst = r; flush = f; mem_valid = v; alu_result = alu; mem_data = md;
    reg_dst = rd; reg_write = we; mem_to_reg = m2r; load_type = lt;
    @(posedge clk);
    #1;
    if (r) begin
      m_cnt_a = 0; m_cnt_b = 0; m_stk_a = 1'b0;
      cur = '{valid: 1'b0, res: 32'd0, mem: 32'd0, rd: 5'd0, we: 1'b0, m2r: 1'b0, lt: 3'd0};
    end else begin
      if (cur.valid) begin
        m_cnt_a = (m_cnt_a + 1) % 16;
        m_cnt_b = m_cnt_b + 1;
      end
      if (cur.valid && cur.m2r && ref_misaligned(cur.res, cur.lt)) m_stk_a = 1'b1;
      cur = '{valid: v && !f, res: alu, mem: md, rd: rd, we: we, m2r: m2r, lt: lt};
    end
    err_a    = cur.valid && cur.m2r && ref_misaligned(cur.res, cur.lt);
    exp_busw = cur.m2r ? ref_load(cur.mem, cur.res, cur.lt) : cur.res;
    check("busw_a",   busw_a,  exp_busw);
    check("busw_b",   busw_b,  exp_busw);
    check("rw_a",     32'(rw_a), 32'(cur.rd));
    check("rw_b",     32'(rw_b), 32'(cur.rd));
    check("regwr_a",  32'(regwr_a), 32'(cur.valid && cur.we && !err_a && cur.rd != 0));
    check("regwr_b",  32'(regwr_b), 32'(cur.valid && cur.we && cur.rd != 0));
    check("wbvalid_a", 32'(wbv_a), 32'(cur.valid));
    check("wbvalid_b", 32'(wbv_b), 32'(cur.valid));
    check("alignerr_a", 32'(aerr_a), 32'(err_a));
    check("alignerr_b", 32'(aerr_b), 32'd0);
    check("sticky_a", 32'(stk_a), 32'(m_stk_a));
    check("sticky_b", 32'(stk_b), 32'd0);
    check("count_a",  32'(cnt_a), m_cnt_a);
    check("count_b",  cnt_b, m_cnt_b);
  endtask

  localparam logic [31:0] LD_WORD = 32'h80F1_7F02;

  initial begin
    // Reset held with a valid writing instruction on the inputs.
    step(1, 0, 1, 32'h0, 32'h0, 5'd5, 1, 0, 3'd0);
    step(1, 0, 1, 32'h0, 32'h0, 5'd5, 1, 0, 3'd0);
    check("reset_regwr", 32'(regwr_a), 32'd0);
    check("reset_count", 32'(cnt_a), 32'd0);
    // First write after release; ALU writeback to r8.
    step(0, 0, 1, 32'h0000_0055, 32'h0, 5'd5, 1, 0, 3'd0);
    step(0, 0, 1, 32'h0000_1234, 32'h0, 5'd8, 1, 0, 3'd0);
    check("alu_busw", busw_a, 32'h0000_1234);
    // Load extraction cases.
    step(0, 0, 1, 32'h1000_0000, LD_WORD, 5'd10, 1, 1, 3'd3);
    check("lb0", busw_a, 32'hFFFF_FF80);
    step(0, 0, 1, 32'h1000_0001, LD_WORD, 5'd10, 1, 1, 3'd4);
    check("lbu1", busw_a, 32'h0000_00F1);
    step(0, 0, 1, 32'h1000_0002, LD_WORD, 5'd10, 1, 1, 3'd3);
    check("lb2", busw_a, 32'h0000_007F);
    step(0, 0, 1, 32'h1000_0000, LD_WORD, 5'd10, 1, 1, 3'd1);
    check("lh0", busw_a, 32'hFFFF_80F1);
    step(0, 0, 1, 32'h1000_0002, LD_WORD, 5'd10, 1, 1, 3'd2);
    check("lhu2", busw_a, 32'h0000_7F02);
    step(0, 0, 1, 32'h1000_0004, LD_WORD, 5'd10, 1, 1, 3'd0);
    check("lw", busw_a, 32'h80F1_7F02);
    // Misaligned lw, then misaligned lh, then a normal instruction.
    step(0, 0, 1, 32'h1000_0002, LD_WORD, 5'd9, 1, 1, 3'd0);
    check("mis_lw_regwr", 32'(regwr_a), 32'd0);
    check("mis_lw_err", 32'(aerr_a), 32'd1);
    step(0, 0, 1, 32'h1000_0001, LD_WORD, 5'd9, 1, 1, 3'd1);
    check("mis_lh_sticky", 32'(stk_a), 32'd1);
    step(0, 0, 1, 32'h0000_0007, 32'h0, 5'd3, 1, 0, 3'd0);
    check("err_pulse_end", 32'(aerr_a), 32'd0);
    // Flush with valid write, then write to r0.
    step(0, 1, 1, 32'h0000_0099, 32'h0, 5'd4, 1, 0, 3'd0);
    check("flush_wbvalid", 32'(wbv_a), 32'd0);
    step(0, 0, 1, 32'h0000_0099, 32'h0, 5'd0, 1, 0, 3'd0);
    check("r0_wbvalid", 32'(wbv_a), 32'd1);
    // Counter wrap from reset with 17 valid instructions and a trailing bubble.
    step(1, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 3'd0);
    for (int i = 0; i < 17; i++)
      step(0, 0, 1, i, 32'h0, 5'(i + 1), 1, 0, 3'd0);
    step(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 3'd0);
    check("wrap_count", 32'(cnt_a), 32'd1);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0), $urandom, $urandom, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
